// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// The slave modport is the sequencer side; master is the requester/consumer side.
interface shift_sequencer_if;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rd_o;
  logic        busy_o;

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, ready_i,
    output ready_o, valid_o, rd_o, busy_o
  );

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, ready_i,
    input  ready_o, valid_o, rd_o, busy_o
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: SLL/SRL/SRA/pass-through, IDLE -> BUSY -> DONE handshake.
// Define SHIFT_FAST_EN to shift up to STEP bits per cycle instead of one.
module shift_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  shift_sequencer_if.slave  sif
);

  if (!(STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
    $error("shift_sequencer: STEP must be 2, 4 or 8");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [31:0] rd_q, rd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  step_k;
  logic [31:0] shifted;
  logic        unused_rs2_hi;

  // Only the low five bits of the shift amount are architecturally meaningful.
  assign unused_rs2_hi = ^sif.rs2_i[31:5];

  always_comb begin
`ifdef SHIFT_FAST_EN
    step_k = (32'(cnt_q) < STEP) ? cnt_q : 5'(STEP);
`else
    step_k = 5'd1;
`endif
  end

  always_comb begin
    case (op_q)
      2'b00:   shifted = work_q << step_k;
      2'b01:   shifted = work_q >> step_k;
      2'b10:   shifted = $signed(work_q) >>> step_k;
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (sif.valid_i) begin
          op_d = sif.op_i;
          if (sif.rs2_i[4:0] == 5'd0 || sif.op_i == 2'b11) begin
            rd_d    = sif.rs1_i;
            state_d = StDone;
          end else begin
            work_d  = sif.rs1_i;
            cnt_d   = sif.rs2_i[4:0];
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        work_d = shifted;
        cnt_d  = cnt_q - step_k;
        if (cnt_q == step_k) begin
          rd_d    = shifted;
          state_d = StDone;
        end
      end
      StDone: begin
        // No accept on this edge: ready_o only rises once back in IDLE.
        if (sif.ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      work_q  <= 32'd0;
      cnt_q   <= 5'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign sif.ready_o = (state_q == StIdle);
  assign sif.valid_o = (state_q == StDone);
  assign sif.busy_o  = (state_q == StBusy);
  assign sif.rd_o    = rd_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table plus random ops, scoreboarded
// results, backpressure, request spacing and mid-operation reset sequences.
module tb_shift_sequencer;
  localparam int unsigned Step = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if sif ();

  shift_sequencer #(.STEP(Step)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sif    (sif)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          hold;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] rs2);
    int sh;
    sh = int'(rs2[4:0]);
    if (op == 2'b11) return 0;
`ifdef SHIFT_FAST_EN
    return (sh + int'(Step) - 1) / int'(Step);
`else
    return sh;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] rs1,
                                        input logic [31:0] rs2);
    case (op)
      2'b00:   return rs1 << rs2[4:0];
      2'b01:   return rs1 >> rs2[4:0];
      2'b10:   return $signed(rs1) >>> rs2[4:0];
      default: return rs1;
    endcase
  endfunction

  task automatic drive_junk();
    sif.valid_i = 1'b1;
    sif.op_i    = 2'($urandom_range(0, 3));
    sif.rs1_i   = $urandom();
    sif.rs2_i   = $urandom();
  endtask

  // Enters at a negedge; returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] exp_rd);
    int   w;
    exp_t e;
    w = 0;
    while (sif.ready_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(sif.ready_o), 32'd1);
    sif.valid_i = 1'b1;
    sif.op_i    = op;
    sif.rs1_i   = rs1;
    sif.rs2_i   = rs2;
    e.rd  = exp_rd;
    e.lat = exp_lat(op, rs2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive_junk();
  endtask

  task automatic collect(input int hold, input logic [31:0] prev_rd);
    int   edges;
    bit   busy_bad;
    bit   rd_bad;
    exp_t e;
    edges    = 0;
    busy_bad = 1'b0;
    rd_bad   = 1'b0;
    while (sif.valid_o !== 1'b1 && edges < 100) begin
      if (sif.busy_o !== 1'b1) busy_bad = 1'b1;
      if (sif.rd_o !== prev_rd) rd_bad = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("valid_o", 32'(sif.valid_o), 32'd1);
    check("latency", 32'(edges), 32'(e.lat));
    check("rd_o", sif.rd_o, e.rd);
    check("busy_while_busy", 32'(busy_bad), 32'd0);
    check("rd_held_busy", 32'(rd_bad), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(sif.valid_o), 32'd1);
      check("hold_rd", sif.rd_o, e.rd);
    end
    // A pending request across the DONE->IDLE edge must not be taken.
    drive_junk();
    sif.ready_i = 1'b1;
    @(posedge clk);
    #1;
    sif.ready_i = 1'b0;
    sif.valid_i = 1'b0;
    check("idle_ready", 32'(sif.ready_o), 32'd1);
    check("idle_valid", 32'(sif.valid_o), 32'd0);
    check("idle_not_busy", 32'(sif.busy_o), 32'd0);
    check("idle_rd_kept", sif.rd_o, e.rd);
  endtask

  vec_t        vecs[7];
  logic [31:0] prev_rd;

  initial begin
    vecs[0] = '{2'b10, 32'h8000_0000, 32'd4,          0, 32'hF800_0000};
    vecs[1] = '{2'b01, 32'h8000_0000, 32'd31,         0, 32'h0000_0001};
    vecs[2] = '{2'b00, 32'h0000_0001, 32'h0000_0021,  0, 32'h0000_0002};
    vecs[3] = '{2'b00, 32'h0000_0001, 32'd0,          1, 32'h0000_0001};
    vecs[4] = '{2'b11, 32'hDEAD_BEEF, 32'd7,          0, 32'hDEAD_BEEF};
    vecs[5] = '{2'b10, 32'hFFFF_0000, 32'd8,          3, 32'hFFFF_FF00};
    vecs[6] = '{2'b00, 32'h0000_00A5, 32'hFFFF_FFE3,  2, 32'h0000_0528};

    sif.valid_i = 1'b0;
    sif.op_i    = 2'b00;
    sif.rs1_i   = 32'd0;
    sif.rs2_i   = 32'd0;
    sif.ready_i = 1'b0;
    prev_rd     = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(sif.ready_o), 32'd1);
    check("rst_valid", 32'(sif.valid_o), 32'd0);
    check("rst_busy", 32'(sif.busy_o), 32'd0);
    check("rst_rd", sif.rd_o, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].exp_rd);
      collect(vecs[i].hold, prev_rd);
      prev_rd = vecs[i].exp_rd;
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] rs1;
      logic [31:0] rs2;
      op  = 2'($urandom_range(0, 3));
      rs1 = $urandom();
      rs2 = $urandom();
      send(op, rs1, rs2, model(op, rs1, rs2));
      collect(i % 3, prev_rd);
      prev_rd = model(op, rs1, rs2);
      @(negedge clk);
    end

    // Reset in the middle of a long SLL.
    send(2'b00, 32'h1234_5678, 32'd20, model(2'b00, 32'h1234_5678, 32'd20));
    @(posedge clk);
    #1;
    check("mid_busy", 32'(sif.busy_o), 32'd1);
    rst_n       = 1'b0;
    sif.valid_i = 1'b0;
    #1;
    check("midrst_ready", 32'(sif.ready_o), 32'd1);
    check("midrst_valid", 32'(sif.valid_o), 32'd0);
    check("midrst_busy", 32'(sif.busy_o), 32'd0);
    check("midrst_rd", sif.rd_o, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b01, 32'h0000_0100, 32'd8, 32'h0000_0001);
    collect(0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: STEP, 4, bits shifted per cycle when SHIFT_FAST_EN is defined; legal values 2, 4 or 8.
REQ-002 Port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: valid_i  input  1  request valid.
REQ-005 Port: ready_o  output  1  sequencer can accept a request.
REQ-006 Port: op_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-007 Port: rs1_i  input  32  operand to shift.
REQ-008 Port: rs2_i  input  32  shift amount source; only rs2_i[4:0] used.
REQ-009 Port: valid_o  output  1  result valid.
REQ-010 Port: ready_i  input  1  consumer accepts result.
REQ-011 Port: rd_o  output  32  result.
REQ-012 Port: busy_o  output  1  high in BUSY state.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; ready_o SHALL be high only in IDLE; valid_o SHALL be high only in DONE.
REQ-014 Accept SHALL occur on a rising edge with IDLE and valid_i=1; op_i, rs1_i and rs2_i[4:0] are registered; rs2_i[31:5] is ignored.
REQ-015 On accept, shamt=0 or op_i=11 SHALL go IDLE->DONE with rd_o=rs1_i; otherwise IDLE->BUSY with working register=rs1_i and remaining count=shamt.
REQ-016 Each BUSY edge SHALL shift the working register by k=1 (k=min(STEP, remaining) with SHIFT_FAST_EN) and decrement remaining by k; SLL fills zeros at LSB, SRL fills zeros at MSB, SRA replicates bit 31.
REQ-017 BUSY SHALL go to DONE on the edge where remaining reaches 0; the result SHALL equal the single-cycle equivalent shift.
REQ-018 valid_o SHALL assert after S rising edges following the accept edge: S=shamt (S=ceil(shamt/STEP) with SHIFT_FAST_EN), S=0 meaning immediately after the accept edge.
REQ-019 In DONE, rd_o and valid_o SHALL hold stable while ready_i=0; on an edge with ready_i=1 the FSM SHALL return to IDLE.
REQ-020 The DONE->IDLE edge SHALL NOT accept a new request; ready_o rises the cycle after, giving a minimum two-cycle request spacing.
REQ-021 valid_i, op_i, rs1_i and rs2_i SHALL be ignored outside IDLE.
REQ-022 rd_o SHALL hold the last result in IDLE and BUSY; it updates only on entry to DONE.

Reset
REQ-023 rst_ni=0 SHALL immediately force IDLE, ready_o=1, valid_o=0, busy_o=0, rd_o=0, and clear the working register and count, including mid-BUSY or mid-DONE.
REQ-024 The first accept SHALL be possible on the first rising edge after rst_ni deasserts.

Configuration
REQ-025 Macro SHIFT_FAST_EN: defined -> multi-bit steps per REQ-016/REQ-018 using STEP; undefined -> one bit per cycle and STEP is unused; function results SHALL be identical in both builds.

Verification
REQ-026 SRA, rs1=0x80000000, rs2=4 -> rd_o=0xF8000000; valid_o after 4 edges (1 with SHIFT_FAST_EN, STEP=4).
REQ-027 SRL, rs1=0x80000000, rs2=31 -> rd_o=0x00000001; valid_o after 31 edges (8 with SHIFT_FAST_EN, STEP=4); busy_o high throughout.
REQ-028 SLL, rs1=0x00000001, rs2=0x00000021 -> upper bits ignored, rd_o=0x00000002 after 1 edge; SLL with rs2=0 -> rd_o=0x00000001, valid_o immediately after accept.
REQ-029 Backpressure: SRA 0xFFFF0000 by 8 with ready_i=0 for 3 cycles in DONE -> rd_o=0xFFFFFF00 held stable and valid_o held; then ready_i=1 -> IDLE, ready_o=1 one cycle later.
REQ-030 Reset mid-op: rst_ni low during BUSY of SLL by 20 -> immediately ready_o=1, valid_o=0, rd_o=0; next request SRL 0x00000100 by 8 -> rd_o=0x00000001.
